fetch_unit: RTL and testbench

Instruction-fetch stage that drives the word-addressed instruction memory and consumes its combinational read data. It owns the program counter, registers each fetched word into an IF/ID slot with a valid/ready handshake, accepts redirects from execute, and traps on misaligned or out-of-range fetch addresses. It sits between the PC/branch logic and the decode stage.

---
 rtl/rv_fetch_pkg.sv | 19 +
 rtl/fetch_addr_check.sv | 26 ++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_ENC        : canonical no-op (addi x0,x0,0) shown when the IF/ID slot is empty
//   fetch_state_e  : fetch sequencer states
//   FAULT_MISALIGN : fault cause, target address not word aligned
//   FAULT_RANGE    : fault cause, target address beyond the instruction memory
package rv_fetch_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic FAULT_MISALIGN = 1'b0;
  localparam logic FAULT_RANGE    = 1'b1;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a fetch byte address.
//   addr  : byte address to check
//   legal : word aligned and below MEM_WORDS*4
//   cause : reason the address is illegal; misalignment wins over range
module fetch_addr_check
  import rv_fetch_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic [31:0] addr,
  output logic        legal,
  output logic        cause
);

  // Compare in 33 bits so a memory of 2^30 words does not overflow the limit.
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic aligned;
  logic in_range;

  assign aligned  = (addr[1:0] == 2'b00);
  assign in_range = ({1'b0, addr} < LIMIT);
  assign legal    = aligned && in_range;
  assign cause    = aligned ? FAULT_RANGE : FAULT_MISALIGN;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a combinational word-addressed
// instruction memory, and registers each fetched word into an IF/ID slot with
// a valid/ready handshake. Redirects from execute flush the slot; misaligned
// or out-of-range fetch targets raise a sticky fault until the next redirect.
// Ports:
//   clk, rst                 : clock (rising edge), asynchronous active-high reset
//   pc_o                     : fetch byte address to memory (memory uses pc_o[31:2])
//   instr_i                  : memory read data for pc_o, same cycle
//   redirect_i/redirect_pc_i : taken branch/jump and its byte target
//   out_valid_o/out_ready_i  : IF/ID slot handshake
//   out_instr_o/out_pc_o     : slot instruction and its byte address
//   fault_o/fault_cause_o/fault_pc_o : sticky fetch fault, cause, offending address
//   fetch_count_o            : completed slot handshakes, wraps mod 2^32
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        fault_o,
  output logic        fault_cause_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         pc_legal;
  logic         pc_cause;
  logic         rpc_legal;
  logic         rpc_cause;
  logic         slot_free;

  assign pc_o      = pc;
  assign slot_free = !out_valid_o || out_ready_i;

  fetch_addr_check #(.MEM_WORDS(MEM_WORDS)) u_pc_check (
    .addr  (pc),
    .legal (pc_legal),
    .cause (pc_cause)
  );

  fetch_addr_check #(.MEM_WORDS(MEM_WORDS)) u_redirect_check (
    .addr  (redirect_pc_i),
    .legal (rpc_legal),
    .cause (rpc_cause)
  );

  // PC -> IF/ID slot register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      out_valid_o   <= 1'b0;
      out_instr_o   <= NOP_INSTR;
      out_pc_o      <= 32'h0;
      fault_o       <= 1'b0;
      fault_cause_o <= 1'b0;
      fault_pc_o    <= 32'h0;
      fetch_count_o <= 32'h0;
    end else begin
      // A handshake completes even in the cycle a redirect flushes the slot.
      if (out_valid_o && out_ready_i) begin
        fetch_count_o <= fetch_count_o + 32'd1;
      end

      if (redirect_i) begin
        out_valid_o <= 1'b0;
        out_instr_o <= NOP_INSTR;
        pc          <= redirect_pc_i;
        if (rpc_legal) begin
          fault_o <= 1'b0;
          state   <= FETCH;
        end else begin
          fault_o       <= 1'b1;
          fault_cause_o <= rpc_cause;
          fault_pc_o    <= redirect_pc_i;
          state         <= FAULT;
        end
      end else begin
        case (state)
          BOOT: begin
            state <= FETCH;
          end
          FETCH: begin
            // When the slot is occupied and not accepted, pc and slot hold.
            if (slot_free) begin
              if (pc_legal) begin
                out_instr_o <= instr_i;
                out_pc_o    <= pc;
                out_valid_o <= 1'b1;
                pc          <= pc + 32'd4;
              end else begin
                out_valid_o   <= 1'b0;
                out_instr_o   <= NOP_INSTR;
                fault_o       <= 1'b1;
                fault_cause_o <= pc_cause;
                fault_pc_o    <= pc;
                state         <= FAULT;
              end
            end
          end
          FAULT: begin
            out_valid_o <= 1'b0;
            out_instr_o <= NOP_INSTR;
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: instance A uses the default 1024-word
// memory, instance B a 4-word memory for the range-fault boundary. Memory
// word k holds (k+1)*0x11, so byte address 0,4,8,0xC,0x40,0x44 read
// 0x11,0x22,0x33,0x44,0x121,0x132.
module tb_fetch_unit;
  import rv_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic [31:0] pc_a, instr_a, rpc_a, oinstr_a, opc_a, fpc_a, cnt_a;
  logic        redir_a, ovalid_a, ready_a, fault_a, fcause_a;
  // Instance B
  logic [31:0] pc_b, instr_b, oinstr_b, opc_b, fpc_b, cnt_b;
  logic        ovalid_b, ready_b, fault_b, fcause_b;

  int checks   = 0;
  int failures = 0;
  slot_t qa[$];
  slot_t qb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    if (idx < 32'd1024) return (idx + 32'd1) * 32'h11;
    return 32'hDEAD_BEEF;
  endfunction

  assign instr_a = mem_word(pc_a);
  assign instr_b = mem_word(pc_b);

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(1024), .NOP_INSTR(32'h0000_0013)) dut_a (
    .clk(clk), .rst(rst), .pc_o(pc_a), .instr_i(instr_a),
    .redirect_i(redir_a), .redirect_pc_i(rpc_a),
    .out_valid_o(ovalid_a), .out_ready_i(ready_a),
    .out_instr_o(oinstr_a), .out_pc_o(opc_a),
    .fault_o(fault_a), .fault_cause_o(fcause_a), .fault_pc_o(fpc_a),
    .fetch_count_o(cnt_a)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4), .NOP_INSTR(32'h0000_0013)) dut_b (
    .clk(clk), .rst(rst), .pc_o(pc_b), .instr_i(instr_b),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .out_valid_o(ovalid_b), .out_ready_i(ready_b),
    .out_instr_o(oinstr_b), .out_pc_o(opc_b),
    .fault_o(fault_b), .fault_cause_o(fcause_b), .fault_pc_o(fpc_b),
    .fetch_count_o(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: a handshake is seen on the falling edge before the rising edge
  // that completes it.
  always @(negedge clk) begin
    if (!rst && ovalid_a && ready_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out_pc", opc_a, 32'hFFFF_FFFF);
      end else begin
        slot_t e;
        e = qa.pop_front();
        chk("a_out_instr", oinstr_a, e.instr);
        chk("a_out_pc", opc_a, e.pc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ovalid_b && ready_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out_pc", opc_b, 32'hFFFF_FFFF);
      end else begin
        slot_t e;
        e = qb.pop_front();
        chk("b_out_instr", oinstr_b, e.instr);
        chk("b_out_pc", opc_b, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    redir_a = 1'b0;
    rpc_a   = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] instr, input logic [31:0] pc);
    slot_t e;
    e.instr = instr;
    e.pc    = pc;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] instr, input logic [31:0] pc);
    slot_t e;
    e.instr = instr;
    e.pc    = pc;
    qb.push_back(e);
  endtask

  task automatic redirect(input logic [31:0] target);
    redir_a = 1'b1;
    rpc_a   = target;
    tick();
    redir_a = 1'b0;
  endtask

  initial begin
    ready_a = 1'b1;
    ready_b = 1'b0;
    redir_a = 1'b0;
    rpc_a   = 32'h0;

    // Phase 1: reset state, then sequential run with decode always ready
    do_reset();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_valid", {31'b0, ovalid_a}, 32'h0);
    chk("rst_instr", oinstr_a, 32'h13);
    chk("rst_out_pc", opc_a, 32'h0);
    chk("rst_fault", {31'b0, fault_a}, 32'h0);
    chk("rst_count", cnt_a, 32'h0);
    push_a(32'h11, 32'h0);
    push_a(32'h22, 32'h4);
    push_a(32'h33, 32'h8);
    tick();
    chk("boot_valid", {31'b0, ovalid_a}, 32'h0);
    tick();
    chk("first_valid", {31'b0, ovalid_a}, 32'h1);
    tick();
    tick();
    tick();
    ready_a = 1'b0;
    chk("run_count", cnt_a, 32'd3);
    chk("run_drain", qa.size(), 32'd0);

    // Phase 2: backpressure after the first word
    ready_a = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_instr", oinstr_a, 32'h11);
      chk("bp_hold_out_pc", opc_a, 32'h0);
      chk("bp_hold_pc", pc_a, 32'h4);
      if (i < 2) tick();
    end
    push_a(32'h11, 32'h0);
    push_a(32'h22, 32'h4);
    ready_a = 1'b1;
    tick();
    tick();
    ready_a = 1'b0;
    chk("bp_count", cnt_a, 32'd2);
    chk("bp_slot_instr", oinstr_a, 32'h33);

    // Phase 3: redirect with a stalled valid slot, then fault/recover
    redirect(32'h40);
    chk("redir_valid", {31'b0, ovalid_a}, 32'h0);
    chk("redir_nop", oinstr_a, 32'h13);
    chk("redir_pc", pc_a, 32'h40);
    tick();
    chk("redir_out_pc", opc_a, 32'h40);
    chk("redir_out_instr", oinstr_a, 32'h121);
    push_a(32'h121, 32'h40);
    ready_a = 1'b1;
    tick();
    // Redirect in the same cycle as a handshake: the handshake still counts.
    push_a(32'h132, 32'h44);
    redirect(32'h42);
    chk("redir_hs_count", cnt_a, 32'd4);
    chk("mis_fault", {31'b0, fault_a}, 32'h1);
    chk("mis_cause", {31'b0, fcause_a}, 32'h0);
    chk("mis_fault_pc", fpc_a, 32'h42);
    chk("mis_valid", {31'b0, ovalid_a}, 32'h0);
    tick();
    chk("fault_hold_valid", {31'b0, ovalid_a}, 32'h0);
    chk("fault_hold_pc", pc_a, 32'h42);
    chk("fault_sticky", {31'b0, fault_a}, 32'h1);
    redirect(32'h8);
    chk("clear_fault", {31'b0, fault_a}, 32'h0);
    chk("clear_pc", pc_a, 32'h8);
    push_a(32'h33, 32'h8);
    tick();
    tick();
    ready_a = 1'b0;
    chk("resume_count", cnt_a, 32'd5);
    chk("resume_out_pc", opc_a, 32'hC);
    redirect(32'h1000);
    chk("range_fault", {31'b0, fault_a}, 32'h1);
    chk("range_cause", {31'b0, fcause_a}, 32'h1);
    chk("range_fault_pc", fpc_a, 32'h1000);
    redirect(32'h1002);
    chk("prio_cause", {31'b0, fcause_a}, 32'h0);
    chk("prio_fault_pc", fpc_a, 32'h1002);
    redirect(32'h0);
    chk("final_clear", {31'b0, fault_a}, 32'h0);
    chk("flush_count", cnt_a, 32'd5);
    chk("redir_drain", qa.size(), 32'd0);

    // Phase 4: asynchronous reset with a valid slot
    ready_a = 1'b0;
    do_reset();
    tick();
    tick();
    chk("pre_arst_valid", {31'b0, ovalid_a}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, ovalid_a}, 32'h0);
    chk("arst_instr", oinstr_a, 32'h13);
    chk("arst_pc", pc_a, 32'h0);
    chk("arst_out_pc", opc_a, 32'h0);
    tick();

    // Phase 5: 4-word memory runs off the end and faults with range cause
    ready_b = 1'b1;
    push_b(32'h11, 32'h0);
    push_b(32'h22, 32'h4);
    push_b(32'h33, 32'h8);
    push_b(32'h44, 32'hC);
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    ready_b = 1'b0;
    chk("b_fault", {31'b0, fault_b}, 32'h1);
    chk("b_cause", {31'b0, fcause_b}, 32'h1);
    chk("b_fault_pc", fpc_b, 32'h10);
    chk("b_pc", pc_b, 32'h10);
    chk("b_valid", {31'b0, ovalid_b}, 32'h0);
    chk("b_count", cnt_b, 32'd4);
    chk("b_drain", qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
